// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source select and load funct3 codes.
package wb_pkg;

  // Result source for the register-file write.
  typedef enum logic [1:0] {
    WbAlu = 2'd0,
    WbMem = 2'd1,
    WbPc4 = 2'd2,
    WbImm = 2'd3
  } wb_sel_e;

  // Load width/sign codes carried in funct3.
  localparam logic [2:0] F3Lb  = 3'd0;
  localparam logic [2:0] F3Lh  = 3'd1;
  localparam logic [2:0] F3Lw  = 3'd2;
  localparam logic [2:0] F3Lbu = 3'd4;
  localparam logic [2:0] F3Lhu = 3'd5;

  // Halfwords must be 2-byte aligned and words 4-byte aligned; other codes never trap.
  function automatic logic is_misaligned(wb_sel_e sel, logic [2:0] funct3, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (sel == WbMem) begin
      if ((funct3 == F3Lh || funct3 == F3Lhu) && addr_lo[0]) mis = 1'b1;
      if (funct3 == F3Lw && addr_lo != 2'b00) mis = 1'b1;
    end
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB slot inputs, pipeline control and register-file/retire outputs of the write-back stage.
interface wb_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 64
);
  logic              in_valid;
  logic              in_reg_write;
  logic [1:0]        in_wb_sel;
  logic [2:0]        in_funct3;
  logic [1:0]        in_addr_lo;
  logic [RA_W-1:0]   in_rd;
  logic [XLEN-1:0]   in_alu_data;
  logic [XLEN-1:0]   in_mem_data;
  logic [XLEN-1:0]   in_pc4;
  logic [XLEN-1:0]   in_imm;
  logic              stall;
  logic              flush;
  logic              rf_we;
  logic [RA_W-1:0]   rf_rd;
  logic [XLEN-1:0]   rf_wdata;
  logic              misalign_exc;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output in_valid, in_reg_write, in_wb_sel, in_funct3, in_addr_lo, in_rd,
    output in_alu_data, in_mem_data, in_pc4, in_imm, stall, flush,
    input  rf_we, rf_rd, rf_wdata, misalign_exc, retire_cnt
  );

  modport slave (
    input  in_valid, in_reg_write, in_wb_sel, in_funct3, in_addr_lo, in_rd,
    input  in_alu_data, in_mem_data, in_pc4, in_imm, stall, flush,
    output rf_we, rf_rd, rf_wdata, misalign_exc, retire_cnt
  );
endinterface

// File: rtl/load_align.sv
// Combinational load alignment: extracts and extends the byte/halfword selected by addr_lo.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the lane, then extend according to the load code; unknown codes pass the raw word.
  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];
    data     = word;
    case (funct3)
      F3Lb:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3Lbu:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3Lh:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3Lhu:   data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM/WB slot, selects the result, raises misaligned-load
// pulses and counts retired instructions.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  logic             valid_q;
  logic             reg_write_q;
  wb_sel_e          wb_sel_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [RA_W-1:0]  rd_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  mem_q;
  logic [XLEN-1:0]  pc4_q;
  logic [XLEN-1:0]  imm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [XLEN-1:0]  load_data;
  logic             misaligned;
  logic             retire;

  // Stage register: flush only kills valid; the payload follows the normal stall rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= WbAlu;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (!bus.stall) begin
        valid_q <= bus.in_valid;
      end
      if (!bus.stall) begin
        reg_write_q <= bus.in_reg_write;
        wb_sel_q    <= wb_sel_e'(bus.in_wb_sel);
        funct3_q    <= bus.in_funct3;
        addr_lo_q   <= bus.in_addr_lo;
        rd_q        <= bus.in_rd;
        alu_q       <= bus.in_alu_data;
        mem_q       <= bus.in_mem_data;
        pc4_q       <= bus.in_pc4;
        imm_q       <= bus.in_imm;
      end
    end
  end

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .word    (mem_q),
    .data    (load_data)
  );

  // Result select, write enable, exception pulse and retire count next-state.
  always_comb begin
    misaligned = is_misaligned(wb_sel_q, funct3_q, addr_lo_q);
    retire     = valid_q & ~bus.stall & ~misaligned;
    cnt_d      = retire ? cnt_q + 1'b1 : cnt_q;

    bus.rf_wdata = alu_q;
    unique case (wb_sel_q)
      WbAlu: bus.rf_wdata = alu_q;
      WbMem: bus.rf_wdata = load_data;
      WbPc4: bus.rf_wdata = pc4_q;
      WbImm: bus.rf_wdata = imm_q;
      default: bus.rf_wdata = alu_q;
    endcase

    bus.rf_we        = retire & reg_write_q & (rd_q != '0);
    bus.rf_rd        = rd_q;
    bus.misalign_exc = valid_q & misaligned & ~bus.stall;
    bus.retire_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed expectations checked with immediate assertions.
module tb_wb_stage;
  import wb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  wb_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(64)) bus ();

  wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Non-selected sources get distinct background values so a wrong mux leg shows up.
  task automatic set_instr(input logic v, input logic rw, input logic [1:0] sel,
                           input logic [2:0] f3, input logic [1:0] al, input logic [4:0] rd,
                           input logic [31:0] d);
    bus.in_valid     = v;
    bus.in_reg_write = rw;
    bus.in_wb_sel    = sel;
    bus.in_funct3    = f3;
    bus.in_addr_lo   = al;
    bus.in_rd        = rd;
    bus.in_alu_data  = (sel == 2'd0) ? d : 32'h0A0A_0A0A;
    bus.in_mem_data  = (sel == 2'd1) ? d : 32'h0B0B_0B0B;
    bus.in_pc4       = (sel == 2'd2) ? d : 32'h0C0C_0C0C;
    bus.in_imm       = (sel == 2'd3) ? d : 32'h0D0D_0D0D;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd31, 32'h1357_9BDF);
    #2 rst_n = 1'b0;
    #1;
    check("reset_we", {63'd0, bus.rf_we}, 64'd0);
    check("reset_exc", {63'd0, bus.misalign_exc}, 64'd0);
    check("reset_rd", {59'd0, bus.rf_rd}, 64'd0);
    check("reset_wdata", {32'd0, bus.rf_wdata}, 64'd0);
    check("reset_cnt", bus.retire_cnt, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // LB / LBU of the top byte 0x80
    set_instr(1'b1, 1'b1, 2'd1, 3'd0, 2'd3, 5'd5, 32'h80FF_1234);
    cyc();
    check("lb_wdata", {32'd0, bus.rf_wdata}, 64'hFFFF_FF80);
    check("lb_we", {63'd0, bus.rf_we}, 64'd1);
    check("lb_rd", {59'd0, bus.rf_rd}, 64'd5);
    check("lb_cnt", bus.retire_cnt, 64'd0);
    set_instr(1'b1, 1'b1, 2'd1, 3'd4, 2'd3, 5'd5, 32'h80FF_1234);
    cyc();
    check("lbu_wdata", {32'd0, bus.rf_wdata}, 64'h0000_0080);
    check("lbu_we", {63'd0, bus.rf_we}, 64'd1);
    check("lbu_cnt", bus.retire_cnt, 64'd1);

    // Misaligned LW
    set_instr(1'b1, 1'b1, 2'd1, 3'd2, 2'd2, 5'd7, 32'h80FF_1234);
    cyc();
    check("lw_mis_exc", {63'd0, bus.misalign_exc}, 64'd1);
    check("lw_mis_we", {63'd0, bus.rf_we}, 64'd0);
    check("lw_mis_cnt", bus.retire_cnt, 64'd2);

    // ALU to x0: no write, still retires
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF);
    cyc();
    check("x0_exc_pulse", {63'd0, bus.misalign_exc}, 64'd0);
    check("x0_we", {63'd0, bus.rf_we}, 64'd0);
    check("x0_wdata", {32'd0, bus.rf_wdata}, 64'hDEAD_BEEF);
    check("x0_cnt", bus.retire_cnt, 64'd2);

    // LH upper half, LHU lower half
    set_instr(1'b1, 1'b1, 2'd1, 3'd1, 2'd2, 5'd3, 32'h80FF_1234);
    cyc();
    check("lh_wdata", {32'd0, bus.rf_wdata}, 64'hFFFF_80FF);
    check("lh_we", {63'd0, bus.rf_we}, 64'd1);
    check("lh_cnt", bus.retire_cnt, 64'd3);
    set_instr(1'b1, 1'b1, 2'd1, 3'd5, 2'd0, 5'd3, 32'h80FF_1234);
    cyc();
    check("lhu_wdata", {32'd0, bus.rf_wdata}, 64'h0000_1234);
    check("lhu_cnt", bus.retire_cnt, 64'd4);

    // PC+4 and IMM sources; IMM with odd addr_lo must not trap
    set_instr(1'b1, 1'b1, 2'd2, 3'd0, 2'd0, 5'd1, 32'h0000_1004);
    cyc();
    check("pc4_wdata", {32'd0, bus.rf_wdata}, 64'h0000_1004);
    check("pc4_cnt", bus.retire_cnt, 64'd5);
    set_instr(1'b1, 1'b1, 2'd3, 3'd3, 2'd1, 5'd2, 32'hABCD_0000);
    cyc();
    check("imm_wdata", {32'd0, bus.rf_wdata}, 64'hABCD_0000);
    check("imm_exc", {63'd0, bus.misalign_exc}, 64'd0);
    check("imm_cnt", bus.retire_cnt, 64'd6);

    // funct3=6 passes the raw word, never traps
    set_instr(1'b1, 1'b1, 2'd1, 3'd6, 2'd3, 5'd11, 32'h0000_55AA);
    cyc();
    check("f3_6_wdata", {32'd0, bus.rf_wdata}, 64'h0000_55AA);
    check("f3_6_exc", {63'd0, bus.misalign_exc}, 64'd0);
    check("f3_6_we", {63'd0, bus.rf_we}, 64'd1);
    check("f3_6_cnt", bus.retire_cnt, 64'd7);

    // Misaligned LHU
    set_instr(1'b1, 1'b1, 2'd1, 3'd5, 2'd1, 5'd12, 32'h80FF_1234);
    cyc();
    check("lhu_mis_exc", {63'd0, bus.misalign_exc}, 64'd1);
    check("lhu_mis_we", {63'd0, bus.rf_we}, 64'd0);
    check("lhu_mis_cnt", bus.retire_cnt, 64'd8);

    // Stall for three cycles with rd9 held
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd9, 32'h1111_1111);
    cyc();
    check("pre_stall_we", {63'd0, bus.rf_we}, 64'd1);
    check("pre_stall_cnt", bus.retire_cnt, 64'd8);
    bus.stall = 1'b1;
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd10, 32'h2222_2222);
    #1;
    check("stall_we_comb", {63'd0, bus.rf_we}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_we", {63'd0, bus.rf_we}, 64'd0);
      check("stall_rd_held", {59'd0, bus.rf_rd}, 64'd9);
      check("stall_cnt", bus.retire_cnt, 64'd8);
    end
    bus.stall = 1'b0;
    #1;
    check("unstall_we", {63'd0, bus.rf_we}, 64'd1);
    check("unstall_wdata", {32'd0, bus.rf_wdata}, 64'h1111_1111);
    cyc();
    check("post_stall_rd", {59'd0, bus.rf_rd}, 64'd10);
    check("post_stall_cnt", bus.retire_cnt, 64'd9);

    // Stall and flush together: nothing retires, slot empties
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    cyc();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_instr(1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 5'd14, 32'h3333_3333);
    #1;
    check("stflush_we", {63'd0, bus.rf_we}, 64'd0);
    check("stflush_cnt", bus.retire_cnt, 64'd9);
    cyc();
    check("stflush_cnt2", bus.retire_cnt, 64'd9);

    // Flush with a retiring instruction in the slot
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd4, 32'h0000_0005);
    cyc();
    bus.flush = 1'b1;
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd13, 32'h4444_4444);
    #1;
    check("flush_cur_we", {63'd0, bus.rf_we}, 64'd1);
    cyc();
    bus.flush = 1'b0;
    check("flush_cnt", bus.retire_cnt, 64'd10);
    check("flush_empty_we", {63'd0, bus.rf_we}, 64'd0);

    // Counter wrap from all-ones
    set_instr(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0, 32'h0);
    cyc();
    force dut.cnt_q = {64{1'b1}};
    #1;
    check("wrap_preload", bus.retire_cnt, {64{1'b1}});
    release dut.cnt_q;
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd6, 32'h0000_0066);
    cyc();
    set_instr(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0, 32'h0);
    cyc();
    check("wrap_cnt", bus.retire_cnt, 64'd0);

    // Asynchronous reset between edges
    set_instr(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd8, 32'h0000_0077);
    cyc();
    cyc();
    check("pre_rst_we", {63'd0, bus.rf_we}, 64'd1);
    check("pre_rst_cnt", bus.retire_cnt, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_we", {63'd0, bus.rf_we}, 64'd0);
    check("async_rst_cnt", bus.retire_cnt, 64'd0);
    check("async_rst_rd", {59'd0, bus.rf_rd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("resume_we", {63'd0, bus.rf_we}, 64'd1);
    check("resume_cnt", bus.retire_cnt, 64'd0);
    cyc();
    check("resume_cnt2", bus.retire_cnt, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data-path width.
REQ-002 SHALL have parameter RA_W, default 5, the register-address width.
REQ-003 SHALL have parameter CNT_W, default 64, the retire-counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; port names are clk and rst_n, as elsewhere in the codebase.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  MEM/WB input slot holds an instruction.
REQ-008 in_reg_write  in  1  instruction writes rd.
REQ-009 in_wb_sel  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM.
REQ-010 in_funct3  in  3  load width/sign code.
REQ-011 in_addr_lo  in  2  low bits of the load address.
REQ-012 in_rd  in  RA_W  destination register.
REQ-013 in_alu_data, in_mem_data, in_pc4, in_imm  in  XLEN each  candidate results; in_mem_data is the raw aligned word.
REQ-014 stall  in  1  hold the stage.
REQ-015 flush  in  1  kill the stage.
REQ-016 rf_we  out  1  register-file write enable.
REQ-017 rf_rd  out  RA_W  register-file write address.
REQ-018 rf_wdata  out  XLEN  register-file write data.
REQ-019 misalign_exc  out  1  misaligned-load pulse.
REQ-020 retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-021 SHALL capture all in_* fields into a stage register on a rising clk when stall=0.
- Write-back result appears on rf_* one cycle after capture.
REQ-022 SHALL hold the stage register unchanged when stall=1 and flush=0.
REQ-023 SHALL clear the stage valid bit at the next edge when flush=1; flush overrides stall and in_valid.
REQ-024 SHALL select rf_wdata from the registered fields by wb_sel: ALU, aligned load, PC+4, or IMM.
REQ-025 SHALL align loads by funct3 and addr_lo:
- LB (0) / LBU (4): byte at addr_lo*8, sign-extended / zero-extended.
- LH (1) / LHU (5): halfword at addr_lo[1]*16, sign-extended / zero-extended.
- LW (2): full word.
- funct3 3, 6 or 7: raw word, no exception.
REQ-026 SHALL flag misaligned when wb_sel=MEM and either (LH/LHU with addr_lo[0]=1) or (LW with addr_lo!=0).
REQ-027 SHALL drive rf_we = valid & reg_write & (rd!=0) & !misaligned & !stall; rf_we is combinational from the stage register and stall.
REQ-028 SHALL drive misalign_exc = valid & misaligned & !stall, a single-cycle pulse per instruction.
REQ-029 SHALL increment retire_cnt by 1 at each edge where valid & !stall & !misaligned.
- x0-targeting and non-writing instructions still retire.
REQ-030 SHALL wrap retire_cnt from 2^CNT_W-1 to 0 without a flag.
REQ-031 SHALL behave as follows when flush and a retiring instruction coincide in one cycle: the current instruction still writes and retires in that cycle; the slot is empty afterwards.
REQ-032 SHALL never assert rf_we for rd=0, whatever the data source.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously clear stage valid, retire_cnt and all registered fields to 0, forcing rf_we=0, misalign_exc=0, rf_rd=0 and rf_wdata=ALU path of 0.
REQ-034 SHALL resume capture at the first rising clk after rst_n deasserts; an instruction in flight at reset is lost and not counted.

Structure
REQ-035 SHALL place the WB_SEL encodings (ALU/MEM/PC4/IMM) and the funct3 load codes in shared package wb_pkg.
REQ-036 SHALL implement the load alignment as combinational sub-module load_align (inputs funct3, addr_lo, word; output XLEN data).

Verification
REQ-037 LB, addr_lo=3, mem=0x80FF_1234, rd=5 -> rf_wdata=0xFFFF_FF80, rf_we=1 one cycle after capture; LBU gives 0x0000_0080.
REQ-038 LW, addr_lo=2, rd=7 -> misalign_exc pulses 1 cycle, rf_we=0, retire_cnt unchanged.
REQ-039 ALU op rd=0, alu=0xDEAD_BEEF -> rf_we=0, retire_cnt +1.
REQ-040 stall=1 for 3 cycles with a valid instruction held -> rf_we=0 throughout; one write and +1 retire in the cycle stall drops; stall+flush together -> slot empty next cycle.
REQ-041 Preload retire_cnt to all-ones via force, retire one instruction -> retire_cnt=0.
REQ-042 Assert rst_n=0 mid-stream, asynchronously between edges -> rf_we and retire_cnt go to 0 immediately, without a clock edge.
